alu_result_mux: RTL and testbench
=================================

ALU_RESULT_MUX -- requirements
Module: alu_result_mux

Interface
REQ-001 Parameter WIDTH, default 4, data width of each input channel and of OUT.
REQ-002 Parameter NUM_IN, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), width of SEL and CH_ID.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 IN_BUS  input  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SEL  input  SEL_W  channel select, used when MODE=0.
REQ-008 MODE  input  1  0 = explicit select via SEL; 1 = round-robin scan via internal pointer.
REQ-009 IN_VALID  input  1  upstream offers a selection this cycle.
REQ-010 IN_READY  output  1  block can accept this cycle.
REQ-011 OUT  output  WIDTH  registered selected data.
REQ-012 OUT_VALID  output  1  OUT, CH_ID, SEL_ERR, ZERO hold a valid result.
REQ-013 OUT_READY  input  1  downstream accepts the result.
REQ-014 CH_ID  output  SEL_W  channel index that produced OUT.
REQ-015 SEL_ERR  output  1  registered flag: the index used was >= NUM_IN.
REQ-016 ZERO  output  1  registered flag: OUT == 0.

Function
REQ-017 Accept condition: IN_VALID && IN_READY; drain condition: OUT_VALID && OUT_READY.
REQ-018 IN_READY shall equal !OUT_VALID || OUT_READY (combinational, single-entry output register).
REQ-019 On accept, OUT, CH_ID, SEL_ERR and ZERO shall load from the current index and OUT_VALID shall be 1 the next cycle (latency 1 cycle).
REQ-020 Index used: SEL when MODE=0, internal pointer PTR when MODE=1.
REQ-021 Index >= NUM_IN: OUT shall load 0, SEL_ERR 1, ZERO 1, and CH_ID the offending index.
REQ-022 On drain with no accept in the same cycle, OUT_VALID shall clear; OUT/CH_ID/flags shall hold their last values.
REQ-023 Simultaneous drain and accept: the new result loads and OUT_VALID stays 1; no bubble and no loss.
REQ-024 While OUT_VALID=1 and OUT_READY=0, OUT, CH_ID, SEL_ERR, ZERO shall be stable regardless of IN_BUS, SEL or MODE changes.
REQ-025 PTR (SEL_W bits) shall advance by 1 only on an accept with MODE=1, wrapping from NUM_IN-1 to 0; PTR never takes an out-of-range value.
REQ-026 PTR shall hold in MODE=0 and across MODE changes; switching MODE never resets PTR.
REQ-027 Data shall pass unmodified; no arithmetic on data; ZERO is a WIDTH-bit all-zero compare.

Reset
REQ-028 RST=1 shall immediately force OUT=0, OUT_VALID=0, CH_ID=0, SEL_ERR=0, ZERO=0, PTR=0, independent of CLK.
REQ-029 During RST=1, IN_READY shall be 1 (follows REQ-018) but no accept shall take effect.
REQ-030 Reset asserted mid-transfer shall discard the held result; the first accept after release uses PTR=0 in MODE=1.

Verification
REQ-031 WIDTH=4, NUM_IN=4, IN_BUS=16'hC835, MODE=0, SEL=2, IN_VALID=1, OUT_READY=1 -> next cycle OUT=4'h8, CH_ID=2, OUT_VALID=1, ZERO=0, SEL_ERR=0.
REQ-032 MODE=1, IN_VALID=1 for 6 cycles, OUT_READY=1, IN_BUS=16'hC835 -> OUT sequence 5,3,8,C,5,3; CH_ID 0,1,2,3,0,1 (wrap).
REQ-033 Back-pressure: OUT_READY=0 after first accept -> IN_READY=0, OUT holds 4'h5 while IN_BUS changes; OUT_READY=1 with IN_VALID=1 -> next value loads same cycle, OUT_VALID stays 1.
REQ-034 NUM_IN=3, MODE=0, SEL=3 accepted -> OUT=0, SEL_ERR=1, ZERO=1, CH_ID=3; MODE=1 scan never shows CH_ID=3.
REQ-035 Channel 1 = 4'h0 selected -> ZERO=1, SEL_ERR=0.
REQ-036 RST pulsed between clock edges while OUT_VALID=1 and PTR=2 -> OUT_VALID=0, OUT=0 immediately; first MODE=1 accept after release yields CH_ID=0.

Source files
------------

// File: rtl/alu_result_mux.sv
// Registered N-way channel selector with explicit or round-robin indexing and a
// single-entry valid/ready output stage; flags out-of-range and all-zero results.
module alu_result_mux #(
   parameter int WIDTH  = 4,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        ch_id,
   output logic                    sel_err,
   output logic                    zero,
   output logic [SEL_W-1:0]        dbg_ptr
);

   // Handshake: a transfer happens on a rising edge where valid && ready; once
   // out_valid is raised the result is held unchanged until out_ready is seen.
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_next;
   logic [SEL_W-1:0] idx;
   logic [WIDTH-1:0] sel_data;
   logic             idx_err;
   logic             accept;
   logic             drain;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;
   assign idx      = mode ? ptr : sel;
   assign dbg_ptr  = ptr;

   // Indices with no matching channel fall through to zero data and the error flag.
   always_comb begin
      sel_data = '0;
      idx_err  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (idx == SEL_W'(k)) begin
            sel_data = in_bus[k*WIDTH +: WIDTH];
            idx_err  = 1'b0;
         end
      end
   end

   always_comb begin
      ptr_next = ptr + 1'b1;
      if (ptr == SEL_W'(NUM_IN - 1)) begin
         ptr_next = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (accept && mode) begin
         ptr <= ptr_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         ch_id     <= '0;
         sel_err   <= 1'b0;
         zero      <= 1'b0;
      end else if (accept) begin
         out       <= sel_data;
         out_valid <= 1'b1;
         ch_id     <= idx;
         sel_err   <= idx_err;
         zero      <= (sel_data == '0);
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_result_mux.sv
// Directed bench for alu_result_mux: a 4-channel and a 3-channel instance, each
// with an expected-result queue drained by an independent monitor.
module tb_alu_result_mux;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Instance A: WIDTH=4, NUM_IN=4
   logic [15:0] bus_a = '0;
   logic [1:0]  sel_a = '0;
   logic        mode_a = 1'b0;
   logic        vin_a = 1'b0;
   logic        rdy_a;
   logic [3:0]  out_a;
   logic        ov_a;
   logic        ordy_a = 1'b1;
   logic [1:0]  id_a;
   logic        err_a;
   logic        zero_a;
   logic [1:0]  ptr_a;

   // Instance B: WIDTH=4, NUM_IN=3
   logic [11:0] bus_b = '0;
   logic [1:0]  sel_b = '0;
   logic        mode_b = 1'b0;
   logic        vin_b = 1'b0;
   logic        rdy_b;
   logic [3:0]  out_b;
   logic        ov_b;
   logic        ordy_b = 1'b1;
   logic [1:0]  id_b;
   logic        err_b;
   logic        zero_b;
   logic [1:0]  ptr_b;

   // Entry layout: {data[3:0], ch_id[1:0], sel_err, zero}
   logic [7:0] exp_q[$];
   logic [7:0] exp_b_q[$];

   alu_result_mux #(.WIDTH(4), .NUM_IN(4)) dut_a (
      .clk(clk), .rst(rst), .in_bus(bus_a), .sel(sel_a), .mode(mode_a),
      .in_valid(vin_a), .in_ready(rdy_a), .out(out_a), .out_valid(ov_a),
      .out_ready(ordy_a), .ch_id(id_a), .sel_err(err_a), .zero(zero_a),
      .dbg_ptr(ptr_a)
   );

   alu_result_mux #(.WIDTH(4), .NUM_IN(3)) dut_b (
      .clk(clk), .rst(rst), .in_bus(bus_b), .sel(sel_b), .mode(mode_b),
      .in_valid(vin_b), .in_ready(rdy_b), .out(out_b), .out_valid(ov_b),
      .out_ready(ordy_b), .ch_id(id_b), .sel_err(err_b), .zero(zero_b),
      .dbg_ptr(ptr_b)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitors: compare whenever a result is drained
   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst && ov_a && ordy_a) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL mon_a_unexpected: got %h expected none at %0t",
                     {out_a, id_a, err_a, zero_a}, $time);
         end else begin
            e = exp_q.pop_front();
            if ({out_a, id_a, err_a, zero_a} !== e) begin
               fails++;
               $display("FAIL mon_a: got %h expected %h at %0t",
                        {out_a, id_a, err_a, zero_a}, e, $time);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst && ov_b && ordy_b) begin
         tests++;
         if (exp_b_q.size() == 0) begin
            fails++;
            $display("FAIL mon_b_unexpected: got %h expected none at %0t",
                     {out_b, id_b, err_b, zero_b}, $time);
         end else begin
            e = exp_b_q.pop_front();
            if ({out_b, id_b, err_b, zero_b} !== e) begin
               fails++;
               $display("FAIL mon_b: got %h expected %h at %0t",
                        {out_b, id_b, err_b, zero_b}, e, $time);
            end
         end
      end
   end

   // Offer one selection and queue its expected result once it will be accepted.
   task automatic send_a(input logic m, input logic [1:0] s, input logic [15:0] bus,
                         input logic [7:0] exp);
      int n = 0;
      mode_a = m; sel_a = s; bus_a = bus; vin_a = 1'b1;
      @(negedge clk);
      while (!rdy_a && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!rdy_a) begin
         tests++; fails++;
         $display("FAIL send_a_timeout: got in_ready=0 expected 1 at %0t", $time);
      end else begin
         exp_q.push_back(exp);
      end
      @(posedge clk); #1;
      vin_a = 1'b0;
   endtask

   task automatic send_b(input logic m, input logic [1:0] s, input logic [11:0] bus,
                         input logic [7:0] exp);
      int n = 0;
      mode_b = m; sel_b = s; bus_b = bus; vin_b = 1'b1;
      @(negedge clk);
      while (!rdy_b && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!rdy_b) begin
         tests++; fails++;
         $display("FAIL send_b_timeout: got in_ready=0 expected 1 at %0t", $time);
      end else begin
         exp_b_q.push_back(exp);
      end
      @(posedge clk); #1;
      vin_b = 1'b0;
   endtask

   initial begin
      // Reset state, with an offer pending that must not be taken
      vin_a = 1'b1; bus_a = 16'hC835; mode_a = 1'b1;
      #2;
      check("rst_outputs", {out_a, id_a, err_a, zero_a}, 8'h00);
      check("rst_valid", {7'd0, ov_a}, 8'd0);
      check("rst_in_ready", {7'd0, rdy_a}, 8'd1);
      repeat (2) @(posedge clk);
      #1;
      check("rst_ptr", {6'd0, ptr_a}, 8'd0);
      check("rst_no_accept", {7'd0, ov_a}, 8'd0);
      vin_a = 1'b0;
      rst = 1'b0;

      // Explicit select of channel 2
      send_a(1'b0, 2'd2, 16'hC835, {4'h8, 2'd2, 1'b0, 1'b0});
      check("lat1_valid", {7'd0, ov_a}, 8'd1);

      // Round-robin scan with wrap
      send_a(1'b1, 2'd0, 16'hC835, {4'h5, 2'd0, 1'b0, 1'b0});
      send_a(1'b1, 2'd0, 16'hC835, {4'h3, 2'd1, 1'b0, 1'b0});
      send_a(1'b1, 2'd0, 16'hC835, {4'h8, 2'd2, 1'b0, 1'b0});
      send_a(1'b1, 2'd0, 16'hC835, {4'hC, 2'd3, 1'b0, 1'b0});
      send_a(1'b1, 2'd0, 16'hC835, {4'h5, 2'd0, 1'b0, 1'b0});
      send_a(1'b1, 2'd0, 16'hC835, {4'h3, 2'd1, 1'b0, 1'b0});

      // Zero-valued channel; pointer must hold in explicit mode
      send_a(1'b0, 2'd1, 16'hC805, {4'h0, 2'd1, 1'b0, 1'b1});
      check("ptr_hold_mode0", {6'd0, ptr_a}, 8'd2);

      // Back-pressure: result held while inputs churn
      @(posedge clk); #1;
      ordy_a = 1'b0;
      send_a(1'b0, 2'd0, 16'hC835, {4'h5, 2'd0, 1'b0, 1'b0});
      vin_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mode_a = i[0]; sel_a = 2'd3; bus_a = 16'h1234 ^ 16'(i * 16'h1111);
         @(negedge clk);
         check("stall_in_ready", {7'd0, rdy_a}, 8'd0);
         check("stall_hold", {out_a, id_a, err_a, zero_a}, {4'h5, 2'd0, 1'b0, 1'b0});
         @(posedge clk); #1;
      end
      mode_a = 1'b0; sel_a = 2'd3; bus_a = 16'h1234;
      check("ptr_hold_stall", {6'd0, ptr_a}, 8'd2);
      ordy_a = 1'b1;
      @(negedge clk);
      check("release_in_ready", {7'd0, rdy_a}, 8'd1);
      exp_q.push_back({4'h1, 2'd3, 1'b0, 1'b0});
      @(posedge clk); #1;
      vin_a = 1'b0;
      check("no_bubble_valid", {7'd0, ov_a}, 8'd1);
      check("no_bubble_data", {4'd0, out_a}, 8'h01);

      // Reset mid-transfer between edges
      @(posedge clk); #1;
      ordy_a = 1'b0;
      send_a(1'b0, 2'd0, 16'hC835, {4'h5, 2'd0, 1'b0, 1'b0});
      check("pre_rst_ptr", {6'd0, ptr_a}, 8'd2);
      check("pre_rst_valid", {7'd0, ov_a}, 8'd1);
      #1 rst = 1'b1;
      #1;
      check("async_rst_valid", {7'd0, ov_a}, 8'd0);
      check("async_rst_outputs", {out_a, id_a, err_a, zero_a}, 8'h00);
      check("async_rst_ptr", {6'd0, ptr_a}, 8'd0);
      exp_q.delete();
      #1 rst = 1'b0;
      ordy_a = 1'b1;
      send_a(1'b1, 2'd0, 16'hC835, {4'h5, 2'd0, 1'b0, 1'b0});

      // Three-channel instance: out-of-range select, then scan that skips index 3
      send_b(1'b0, 2'd3, 12'h835, {4'h0, 2'd3, 1'b1, 1'b1});
      send_b(1'b1, 2'd0, 12'h835, {4'h5, 2'd0, 1'b0, 1'b0});
      send_b(1'b1, 2'd0, 12'h835, {4'h3, 2'd1, 1'b0, 1'b0});
      send_b(1'b1, 2'd0, 12'h835, {4'h8, 2'd2, 1'b0, 1'b0});
      send_b(1'b1, 2'd0, 12'h835, {4'h5, 2'd0, 1'b0, 1'b0});
      send_b(1'b1, 2'd0, 12'h835, {4'h3, 2'd1, 1'b0, 1'b0});

      repeat (4) @(posedge clk);
      check("queue_a_empty", 8'(exp_q.size()), 8'd0);
      check("queue_b_empty", 8'(exp_b_q.size()), 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
